rc4_key_search_ctrl: RTL

- Top-level scheduler for the RC4 brute-force decryptor.
- Steps a 24-bit candidate key through the three loop FSMs in order: S-init, key schedule, decrypt.
- Arbitrates the single S-RAM port between the three loops.
- Samples the decrypt loop's `valid` result, then either stops on a hit or advances to the next key.

---
 rtl/rc4_key_search_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rc4_key_search_ctrl.sv
// Top-level scheduler for the RC4 brute-force key search: sequences S-init, key schedule and
// decrypt per candidate key and muxes the shared S-RAM port. Optional watchdog: RC4_KEY_SEARCH_WATCHDOG_EN.
module rc4_key_search_ctrl #(
    parameter logic [23:0] KEY_START   = 24'h000000,
    parameter logic [23:0] KEY_MAX     = 24'h3FFFFF,
    parameter logic [19:0] WDOG_CYCLES = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    output logic        init_start,
    input  logic        init_finish,
    output logic        ksa_start,
    input  logic        ksa_finish,
    output logic        dec_start,
    input  logic        dec_finish,
    input  logic        dec_valid,
    input  logic [7:0]  s1_address,
    input  logic [7:0]  s1_data,
    input  logic        s1_wren,
    input  logic [7:0]  s2_address,
    input  logic [7:0]  s2_data,
    input  logic        s2_wren,
    input  logic [7:0]  s3_address,
    input  logic [7:0]  s3_data,
    input  logic        s3_wren,
    output logic [7:0]  s_address,
    output logic [7:0]  s_data,
    output logic        s_wren,
    output logic [23:0] secret_key,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        fail,
    output logic        timeout
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_REQ, S_INIT_WAIT, S_KSA_REQ, S_KSA_WAIT,
        S_DEC_REQ, S_DEC_WAIT, S_CHECK, S_FOUND, S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] key_q, key_d;
    logic        hit_q, hit_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        found_q, found_d;
    logic        fail_q, fail_d;
    logic        timeout_q, timeout_d;
    logic        in_stage;
    logic        wdog_expired;

    assign in_stage = (state_q == S_INIT_REQ) || (state_q == S_INIT_WAIT) ||
                      (state_q == S_KSA_REQ)  || (state_q == S_KSA_WAIT)  ||
                      (state_q == S_DEC_REQ)  || (state_q == S_DEC_WAIT);

`ifdef RC4_KEY_SEARCH_WATCHDOG_EN
    logic [19:0] wdog_q, wdog_d;
    logic        entering_req;

    assign entering_req = (state_d != state_q) &&
                          ((state_d == S_INIT_REQ) || (state_d == S_KSA_REQ) || (state_d == S_DEC_REQ));
    assign wdog_expired = in_stage && (wdog_q == WDOG_CYCLES - 20'd1);

    always_comb begin
        wdog_d = wdog_q;
        if (entering_req) begin
            wdog_d = '0;
        end else if (in_stage) begin
            wdog_d = wdog_q + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog  = ^WDOG_CYCLES;
    assign wdog_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            key_q     <= KEY_START;
            hit_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            hit_q     <= hit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            found_q   <= found_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        hit_d     = hit_q;
        busy_d    = busy_q;
        done_d    = done_q;
        found_d   = found_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        case (state_q)
            // Only start when every loop is idle, so a loop left running by a reset cannot collide.
            S_IDLE: begin
                if (go && init_finish && ksa_finish && dec_finish) begin
                    state_d   = S_INIT_REQ;
                    key_d     = KEY_START;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    found_d   = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_INIT_REQ:  if (!init_finish) state_d = S_INIT_WAIT;
            S_INIT_WAIT: if (init_finish)  state_d = S_KSA_REQ;
            S_KSA_REQ:   if (!ksa_finish)  state_d = S_KSA_WAIT;
            S_KSA_WAIT:  if (ksa_finish)   state_d = S_DEC_REQ;
            S_DEC_REQ:   if (!dec_finish)  state_d = S_DEC_WAIT;
            // dec_valid is only meaningful on the first finish cycle; the loop re-arms it soon after.
            S_DEC_WAIT: begin
                if (dec_finish) begin
                    hit_d   = dec_valid;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hit_q) begin
                    state_d = S_FOUND;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    found_d = 1'b1;
                end else if (key_q == KEY_MAX) begin
                    state_d = S_FAIL;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                end else begin
                    key_d   = key_q + 24'd1;
                    state_d = S_INIT_REQ;
                end
            end
            S_FOUND, S_FAIL: if (!go) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (wdog_expired) begin
            state_d   = S_FAIL;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            fail_d    = 1'b1;
            timeout_d = 1'b1;
        end
    end

    always_comb begin
        init_start = (state_q == S_INIT_REQ);
        ksa_start  = (state_q == S_KSA_REQ);
        dec_start  = (state_q == S_DEC_REQ);
        s_address  = 8'h00;
        s_data     = 8'h00;
        s_wren     = 1'b0;
        case (state_q)
            S_INIT_REQ, S_INIT_WAIT: begin
                s_address = s1_address;
                s_data    = s1_data;
                s_wren    = s1_wren;
            end
            S_KSA_REQ, S_KSA_WAIT: begin
                s_address = s2_address;
                s_data    = s2_data;
                s_wren    = s2_wren;
            end
            S_DEC_REQ, S_DEC_WAIT: begin
                s_address = s3_address;
                s_data    = s3_data;
                s_wren    = s3_wren;
            end
            default: ;
        endcase
        secret_key = key_q;
        busy       = busy_q;
        done       = done_q;
        found      = found_q;
        fail       = fail_q;
        timeout    = timeout_q;
    end

endmodule
